// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer: 1 s tick generator, per-phase seconds
// countdown, optional pedestrian-walk phase and lamp decode.
module traffic_phase_controller #(
   parameter int unsigned TICK_CYCLES = 50000000,
   parameter int unsigned GREEN_SEC   = 10,
   parameter int unsigned YELLOW_SEC  = 3,
   parameter int unsigned ALLRED_SEC  = 1,
   parameter int unsigned PED_SEC     = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       hold,
   output logic [7:0] second,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic       ped_walk,
   output logic [2:0] phase,
   output logic       tick
);

   localparam logic [2:0] NS_G = 3'd0, NS_Y = 3'd1, AR_A = 3'd2, EW_G = 3'd3,
                          EW_Y = 3'd4, AR_B = 3'd5, PED  = 3'd6;
   localparam logic [31:0] TERM = 32'(TICK_CYCLES - 1);

   logic [31:0] cnt;
   logic        tick_r;
   logic        ped_pending;
   logic [2:0]  state, state_nx;
   logic [7:0]  sec_nx;
   logic        pend_nx;
   logic        step;

   function automatic logic [7:0] load_val(input logic [2:0] p);
      case (p)
         NS_G, EW_G: load_val = 8'(GREEN_SEC);
         NS_Y, EW_Y: load_val = 8'(YELLOW_SEC);
         AR_A, AR_B: load_val = 8'(ALLRED_SEC);
         default:    load_val = 8'(PED_SEC);
      endcase
   endfunction

   assign step = (cnt == TERM) && !hold;

   // State register, including the seconds countdown and pedestrian latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= NS_G;
         second      <= 8'(GREEN_SEC);
         cnt         <= '0;
         tick_r      <= 1'b0;
         ped_pending <= 1'b0;
      end else begin
         state       <= state_nx;
         second      <= sec_nx;
         ped_pending <= pend_nx;
         tick_r      <= step;
         if (!hold) cnt <= (cnt == TERM) ? '0 : cnt + 32'd1;
      end
   end

   always_comb begin
      state_nx = state;
      sec_nx   = second;
      if (state > PED) begin
         state_nx = NS_G;
         sec_nx   = 8'(GREEN_SEC);
      end else if (step) begin
         if (second != 8'd0) begin
            sec_nx = second - 8'd1;
         end else begin
            case (state)
               AR_B:    state_nx = ped_pending ? PED : NS_G;
               PED:     state_nx = NS_G;
               default: state_nx = state + 3'd1;
            endcase
            sec_nx = load_val(state_nx);
         end
      end
      // Entering PED serves the request, even one arriving on that same edge.
      pend_nx = ped_pending;
      if (state_nx == PED && state != PED) pend_nx = 1'b0;
      else if (ped_req && state != PED)    pend_nx = 1'b1;
   end

   always_comb begin
      light_ns = 3'b001;
      light_ew = 3'b001;
      ped_walk = 1'b0;
      case (state)
         NS_G:    light_ns = 3'b100;
         NS_Y:    light_ns = 3'b010;
         EW_G:    light_ew = 3'b100;
         EW_Y:    light_ew = 3'b010;
         PED:     ped_walk = 1'b1;
         default: ;
      endcase
   end

   assign phase = state;
   assign tick  = tick_r & ~hold;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench: two controllers (default and zero yellow/all-red) share stimulus and are
// checked each cycle against a seconds/phase model plus literal expectations.
module tb_traffic_phase_controller;

   logic clk = 1'b0, reset = 1'b1, ped_req = 1'b0, hold = 1'b0;
   logic [7:0] second [2];
   logic [2:0] light_ns [2], light_ew [2], phase [2];
   logic       ped_walk [2], tick [2];

   int n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   traffic_phase_controller #(.TICK_CYCLES(4)) dut0 (
      .clk(clk), .reset(reset), .ped_req(ped_req), .hold(hold),
      .second(second[0]), .light_ns(light_ns[0]), .light_ew(light_ew[0]),
      .ped_walk(ped_walk[0]), .phase(phase[0]), .tick(tick[0]));

   traffic_phase_controller #(.TICK_CYCLES(4), .YELLOW_SEC(0), .ALLRED_SEC(0)) dut1 (
      .clk(clk), .reset(reset), .ped_req(ped_req), .hold(hold),
      .second(second[1]), .light_ns(light_ns[1]), .light_ew(light_ew[1]),
      .ped_walk(ped_walk[1]), .phase(phase[1]), .tick(tick[1]));

   // Model: sub = clk cycles elapsed in the current second, sec = shown value.
   int m_sub [2], m_sec [2], m_ph [2];
   bit m_pend [2], m_tr [2];

   function automatic int ld(input int i, input int ph);
      case (ph)
         0, 3:    return 10;
         1, 4:    return (i == 0) ? 3 : 0;
         2, 5:    return (i == 0) ? 1 : 0;
         default: return 7;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         bit st;
         int nph;
         if (reset) begin
            m_sub[i] = 0; m_sec[i] = 10; m_ph[i] = 0; m_pend[i] = 0; m_tr[i] = 0;
         end else begin
            st = (m_sub[i] == 3) && !hold;
            if (!hold) m_sub[i] = (m_sub[i] + 1) % 4;
            m_tr[i] = st;
            nph = m_ph[i];
            if (st) begin
               if (m_sec[i] > 0) m_sec[i] = m_sec[i] - 1;
               else begin
                  if (m_ph[i] == 5)      nph = m_pend[i] ? 6 : 0;
                  else if (m_ph[i] == 6) nph = 0;
                  else                   nph = m_ph[i] + 1;
                  m_sec[i] = ld(i, nph);
               end
            end
            if (nph == 6 && m_ph[i] != 6)     m_pend[i] = 0;
            else if (ped_req && m_ph[i] != 6) m_pend[i] = 1;
            m_ph[i] = nph;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         logic [2:0] ens, eew;
         ens = {m_ph[i] == 0, m_ph[i] == 1, !(m_ph[i] == 0 || m_ph[i] == 1)};
         eew = {m_ph[i] == 3, m_ph[i] == 4, !(m_ph[i] == 3 || m_ph[i] == 4)};
         chk($sformatf("phase%0d", i), int'(phase[i]), m_ph[i]);
         chk($sformatf("second%0d", i), int'(second[i]), m_sec[i]);
         chk($sformatf("light_ns%0d", i), int'(light_ns[i]), int'(ens));
         chk($sformatf("light_ew%0d", i), int'(light_ew[i]), int'(eew));
         chk($sformatf("ped_walk%0d", i), int'(ped_walk[i]), int'(m_ph[i] == 6));
         chk($sformatf("tick%0d", i), int'(tick[i]), int'(m_tr[i] && !hold));
         chk($sformatf("safety%0d", i),
             int'(!((light_ns[i][2:1] != 0) && (light_ew[i][2:1] != 0)) &&
                  !(ped_walk[i] && (light_ns[i][2] || light_ew[i][2]))), 1);
         chk($sformatf("tick_hold%0d", i), int'(tick[i] && hold), 0);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_for(input string name, input int ph, input int sec,
                           input int lim, output int n);
      n = 0;
      while (!(phase[0] == 3'(ph) && (sec < 0 || second[0] == 8'(sec))) && n < lim) begin
         step();
         n++;
      end
      chk(name, int'(n < lim), 1);
   endtask

   initial begin
      int n;
      bit saw6;
      // Reset state
      repeat (2) @(negedge clk);
      check_all();
      chk("rst_phase", int'(phase[0]), 0);
      chk("rst_second", int'(second[0]), 10);
      chk("rst_ns", int'(light_ns[0]), 3'b100);
      chk("rst_ew", int'(light_ew[0]), 3'b001);
      chk("rst_tick", int'(tick[0]), 0);
      reset = 1'b0;

      // Nominal cycle
      for (int c = 1; c <= 136; c++) begin
         step();
         if (c == 43)  chk("ns_g_end_sec", int'(second[0]), 0);
         if (c == 44)  begin chk("ns_y_phase", int'(phase[0]), 1); chk("ns_y_sec", int'(second[0]), 3); end
         if (c == 136) begin chk("cycle_phase", int'(phase[0]), 0); chk("cycle_sec", int'(second[0]), 10); end
      end

      // Pedestrian request during EW_G
      wait_for("wait_ew_g", 3, -1, 200, n);
      ped_req = 1'b1; step(); ped_req = 1'b0;
      wait_for("wait_ped", 6, 7, 200, n);
      chk("ped_walk_on", int'(ped_walk[0]), 1);
      wait_for("wait_after_ped", 0, 10, 100, n);
      chk("ped_len", n, 32);
      wait_for("wait_ar_b0", 5, 0, 200, n);
      repeat (4) step();
      chk("ped_skipped", int'(phase[0]), 0);

      // Hold mid NS_G at second 6
      wait_for("wait_sec6", 0, 6, 200, n);
      step();
      hold = 1'b1;
      repeat (20) begin
         step();
         chk("hold_sec", int'(second[0]), 6);
         chk("hold_tick", int'(tick[0]), 0);
      end
      hold = 1'b0;
      n = 0;
      do begin step(); n++; end while (!tick[0] && n < 10);
      chk("hold_resume_cycles", n, 3);
      chk("hold_resume_sec", int'(second[0]), 5);

      // Async reset mid EW_Y with a pending request
      wait_for("wait_ew_y2", 4, 2, 300, n);
      ped_req = 1'b1; step(); ped_req = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_all();
      chk("arst_phase", int'(phase[0]), 0);
      chk("arst_sec", int'(second[0]), 10);
      chk("arst_ns", int'(light_ns[0]), 3'b100);
      chk("arst_ew", int'(light_ew[0]), 3'b001);
      repeat (2) step();
      reset = 1'b0;
      saw6 = 0;
      for (int c = 1; c <= 136; c++) begin
         step();
         if (phase[0] == 3'd6) saw6 = 1;
         if (c == 44)  begin chk("z_y_phase", int'(phase[1]), 1); chk("z_y_sec", int'(second[1]), 0); end
         if (c == 48)  begin chk("z_ar_phase", int'(phase[1]), 2); chk("z_ar_sec", int'(second[1]), 0); end
         if (c == 52)  begin chk("z_ewg_phase", int'(phase[1]), 3); chk("z_ewg_sec", int'(second[1]), 10); end
         if (c == 136) chk("arst_cycle_phase", int'(phase[0]), 0);
      end
      chk("arst_pend_cleared", int'(saw6), 0);

      // Random ped_req / hold run
      for (int c = 0; c < 4000; c++) begin
         ped_req = ($urandom_range(0, 7) == 0);
         if (hold) hold = ($urandom_range(0, 2) != 0);
         else      hold = ($urandom_range(0, 11) == 0);
         step();
      end
      ped_req = 1'b0; hold = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
